// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, checked parallel load and wrap/saturate limits.
// Define BCD_CNT_SATURATE_EN to let the sat port select saturation; otherwise the counter always wraps.
module bcd_updown_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  sat,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  at_limit,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         at_limit_q, at_limit_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] inc_val, dec_val;
  logic         all9, all0, load_ok, sat_active;

`ifdef BCD_CNT_SATURATE_EN
  assign sat_active = sat;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign sat_active = 1'b0;
`endif

  // A digit only moves while every lower digit is at its rollover value.
  always_comb begin
    logic carry;
    inc_val = count_q;
    carry   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    all9 = carry;
  end

  always_comb begin
    logic borrow;
    dec_val = count_q;
    borrow  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    all0 = borrow;
  end

  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    at_limit_d = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) count_d    = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (up) begin
        if (all9 && sat_active) begin
          at_limit_d = 1'b1;
        end else begin
          count_d = inc_val;
          wrap_d  = all9;
        end
      end else begin
        if (all0 && sat_active) begin
          at_limit_d = 1'b1;
        end else begin
          count_d = dec_val;
          wrap_d  = all0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      at_limit_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      at_limit_q <= at_limit_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign at_limit = at_limit_q;
  assign load_err = load_err_q;

endmodule
